// File: rtl/arith_pkg.sv
// Shared arithmetic constants and helpers for the pipelined subtractor.
package arith_pkg;

    localparam int W      = 12;
    localparam int HALF_W = 6;

    // Two's-complement overflow of a subtraction, from the operand and
    // result sign bits. The overflow can only happen when the operand
    // signs differ and the result sign differs from the minuend sign.
    function automatic logic calc_ovf(
        input logic x_msb,
        input logic y_msb,
        input logic d_msb
    );
        return (x_msb != y_msb) && (d_msb != x_msb);
    endfunction

endpackage

// File: rtl/sub_6_slice.sv
// Combinational slice subtractor: d = a - b - borrow_in, with borrow out.
module sub_6_slice
    import arith_pkg::*;
#(
    parameter int SW = HALF_W
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          borrow_in,
    output logic [SW-1:0] d,
    output logic          borrow_out
);

    logic [SW:0] sum_s;

    // Subtract as a + ~b + ~borrow_in. The carry out of the top bit is
    // the inverse of the borrow.
    always_comb begin
        sum_s      = {1'b0, a} + {1'b0, ~b} + {{SW{1'b0}}, ~borrow_in};
        d          = sum_s[SW-1:0];
        borrow_out = ~sum_s[SW];
    end

endmodule

// File: rtl/pipe_12_subtractor.sv
// Two-stage pipelined subtractor with valid/ready handshakes on both sides.
// Stage 1 resolves the low slice and registers the inter-slice borrow;
// stage 2 resolves the high slice and the borrow-out / overflow flags.
// W must equal 2*HALF_W; other combinations are not supported.
module pipe_12_subtractor
    import arith_pkg::*;
#(
    parameter int W      = arith_pkg::W,
    parameter int HALF_W = arith_pkg::HALF_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    // Stage-1 state
    logic              s1_valid_r;
    logic [HALF_W-1:0] s1_diff_lo_r;
    logic              s1_mid_borrow_r;
    logic [HALF_W-1:0] s1_x_hi_r;
    logic [HALF_W-1:0] s1_y_hi_r;

    // Handshake / slice results
    logic              s2_adv_s;
    logic              s1_adv_s;
    logic              in_xfer_s;
    logic [HALF_W-1:0] d_lo_s;
    logic              borrow_lo_s;
    logic [HALF_W-1:0] d_hi_s;
    logic              borrow_hi_s;

    // Advance conditions: a stage may move when its successor is empty or
    // draining this cycle. in_ready never looks at in_valid.
    always_comb begin
        s2_adv_s  = !out_valid || out_ready;
        s1_adv_s  = !s1_valid_r || s2_adv_s;
        in_ready  = s1_adv_s;
        in_xfer_s = in_valid && s1_adv_s;
    end

    sub_6_slice #(.SW(HALF_W)) u_slice_lo (
        .a          (x[HALF_W-1:0]),
        .b          (y[HALF_W-1:0]),
        .borrow_in  (bin),
        .d          (d_lo_s),
        .borrow_out (borrow_lo_s)
    );

    sub_6_slice #(.SW(HALF_W)) u_slice_hi (
        .a          (s1_x_hi_r),
        .b          (s1_y_hi_r),
        .borrow_in  (s1_mid_borrow_r),
        .d          (d_hi_s),
        .borrow_out (borrow_hi_s)
    );

    // Stage 1: capture the low-slice result and the high operand halves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r      <= 1'b0;
            s1_diff_lo_r    <= {HALF_W{1'b0}};
            s1_mid_borrow_r <= 1'b0;
            s1_x_hi_r       <= {HALF_W{1'b0}};
            s1_y_hi_r       <= {HALF_W{1'b0}};
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_xfer_s;
            end
            if (in_xfer_s) begin
                s1_diff_lo_r    <= d_lo_s;
                s1_mid_borrow_r <= borrow_lo_s;
                s1_x_hi_r       <= x[W-1:HALF_W];
                s1_y_hi_r       <= y[W-1:HALF_W];
            end
        end
    end

    // Stage 2: complete the high slice and register the visible result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= {W{1'b0}};
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (s2_adv_s) begin
                out_valid <= s1_valid_r;
                if (s1_valid_r) begin
                    diff <= {d_hi_s, s1_diff_lo_r};
                    bout <= borrow_hi_s;
                    ovf  <= calc_ovf(s1_x_hi_r[HALF_W-1], s1_y_hi_r[HALF_W-1],
                                     d_hi_s[HALF_W-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_12_subtractor.sv
// Self-checking bench for pipe_12_subtractor: directed vectors, a stalled
// stream, mid-flight reset and a long random run against a queue model.
module tb_pipe_12_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] x;
    logic [11:0] y;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] diff;
    logic        bout;
    logic        ovf;

    pipe_12_subtractor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] d;
        logic        b;
        logic        o;
        int          t;
    } exp_t;

    exp_t q[$];
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic last_acc;

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t ref_sub(input logic [11:0] a, input logic [11:0] b,
                                     input logic c, input int t);
        exp_t r;
        int ua, ub, sa, sb, full, sd;
        ua   = int'(a);
        ub   = int'(b);
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        full = (ua - ub - int'(c)) + 4096;
        r.d  = full[11:0];
        r.b  = (ua < ub + int'(c));
        sd   = sa - sb - int'(c);
        r.o  = (sd > 2047) || (sd < -2048);
        r.t  = t;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: apply inputs, check outputs against the model, advance.
    task automatic cycle(input logic rst, input logic iv, input logic [11:0] xx,
                         input logic [11:0] yy, input logic bb, input logic ordy);
        logic exp_ready;
        logic exp_valid;
        rst_n     = ~rst;
        in_valid  = iv;
        x         = xx;
        y         = yy;
        bin       = bb;
        out_ready = ordy;
        #1;
        last_acc = 1'b0;
        if (!rst) begin
            exp_ready = (q.size() < 2) || ordy;
            exp_valid = (q.size() > 0) && ((cyc - q[0].t) >= 2);
            chk("in_ready", {11'd0, in_ready}, {11'd0, exp_ready});
            chk("out_valid", {11'd0, out_valid}, {11'd0, exp_valid});
            if (exp_valid) begin
                chk("diff", diff, q[0].d);
                chk("bout", {11'd0, bout}, {11'd0, q[0].b});
                chk("ovf", {11'd0, ovf}, {11'd0, q[0].o});
                if (ordy) void'(q.pop_front());
            end
            if (iv && exp_ready) begin
                q.push_back(ref_sub(xx, yy, bb, cyc));
                last_acc = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            q.delete();
            chk("rst_out_valid", {11'd0, out_valid}, 12'd0);
            chk("rst_diff", diff, 12'd0);
            chk("rst_bout", {11'd0, bout}, 12'd0);
            chk("rst_ovf", {11'd0, ovf}, 12'd0);
            chk("rst_in_ready", {11'd0, in_ready}, 12'd1);
        end
    endtask

    // Single operation with a fixed expected result checked at latency 2.
    task automatic directed(input string tag, input logic [11:0] xx, input logic [11:0] yy,
                            input logic bb, input logic [11:0] ed, input logic eb,
                            input logic eo);
        cycle(1'b0, 1'b1, xx, yy, bb, 1'b1);
        cycle(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        chk({tag, "_valid"}, {11'd0, out_valid}, 12'd1);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bout"}, {11'd0, bout}, {11'd0, eb});
        chk({tag, "_ovf"}, {11'd0, ovf}, {11'd0, eo});
        cycle(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int sent;
        int n;

        // Reset
        cycle(1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0);

        // Directed corner vectors
        directed("borrow0", 12'h000, 12'h001, 1'b0, 12'hFFF, 1'b1, 1'b0);
        directed("ovf_neg", 12'h800, 12'h001, 1'b0, 12'h7FF, 1'b0, 1'b1);
        directed("ovf_pos", 12'h7FF, 12'hFFF, 1'b0, 12'h800, 1'b1, 1'b1);
        directed("mid_b",   12'h040, 12'h001, 1'b0, 12'h03F, 1'b0, 1'b0);
        directed("mid_bin", 12'h040, 12'h000, 1'b1, 12'h03F, 1'b0, 1'b0);
        directed("eq_bin",  12'h005, 12'h005, 1'b1, 12'hFFF, 1'b1, 1'b0);

        // Streaming with out_ready low for cycles 3-5
        sent = 0;
        n    = 0;
        while (n < 20) begin
            cycle(1'b0, (sent < 4) ? 1'b1 : 1'b0, 12'h100 + 12'(sent), 12'(sent), 1'b0,
                  (n >= 2 && n <= 4) ? 1'b0 : 1'b1);
            if (last_acc) sent++;
            n++;
        end
        chk("stream_sent", 12'(sent), 12'd4);

        // Reset with two operations in flight
        cycle(1'b0, 1'b1, 12'h123, 12'h045, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 12'h456, 12'h078, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        end

        // Random traffic with random backpressure
        for (int i = 0; i < 10000; i++) begin
            cycle(1'b0, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  12'($urandom), 12'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_12_subtractor.md
Name: pipe_12_subtractor

Overview:
- Two-stage pipelined 12-bit subtractor with borrow-in, borrow-out and signed overflow flag; this is the inverse arithmetic direction of the team's tree adders.
- Stage 1 resolves the low 6-bit slice. Stage 2 resolves the high slice using the registered inter-slice borrow.
- Sits between the operand source and the ALU result mux.
- Uses a valid/ready handshake on both sides, sustains one result per cycle, and propagates backpressure.

Parameters:
- W, 12, operand/result width.
- HALF_W, 6, slice width. W must equal 2*HALF_W; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- x  input  W  minuend, unsigned or two's complement.
- y  input  W  subtrahend.
- bin  input  1  borrow in.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- diff  output  W  (x - y - bin) mod 2^W.
- bout  output  1  borrow out: 1 iff unsigned x < y + bin.
- ovf  output  1  two's-complement overflow.

Behaviour:
- Arithmetic: diff = x + ~y + ~bin, with carry into bit 0 = ~bin. bout = ~(carry out of bit W-1). ovf = (x[W-1] != y[W-1]) && (diff[W-1] != x[W-1]).
- Accept: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stage 1 registers: s1_valid, the low diff slice, mid_borrow (borrow out of bit HALF_W-1), x_hi, y_hi.
- Stage 2 registers: out_valid, diff, bout, ovf.
- Advance rules:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. This is combinational from out_ready and the registers, with no combinational dependency on in_valid.
- Stage 1 load: on s1_adv, s1_valid <= in_valid && in_ready. Data registers load only on an input transfer; otherwise they hold.
- Stage 2 load: on s2_adv, out_valid <= s1_valid. Data registers load only when s1_valid.
- Latency: exactly 2 cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Backpressure:
  - When out_ready = 0 with both stages full, in_ready drops to 0 and all registers hold.
  - Outputs stay stable while out_valid && !out_ready.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle with both stages full: both stages shift and no data is lost or duplicated.
  - Bubble in stage 1 with stage 2 stalled: stage 1 still fills, so in_ready = 1.
- Reset (rst_n = 0 at a clock edge):
  - out_valid, s1_valid = 0; diff = 0, bout = 0, ovf = 0; all stage-1 data = 0.
  - in_ready = 1 from the first cycle after reset.
  - Reset mid-operation discards in-flight data. No partial result is ever presented.
- Wrap-around: results are modulo 2^W with no saturation.

Decomposition:
- Shared package (arith_pkg): W and HALF_W constants; a function computing ovf from the operand and result sign bits.
- Sub-module sub_6_slice: combinational HALF_W-bit slice with inputs a, b, borrow_in and outputs d, borrow_out. It is instantiated twice, once per stage.
- Pipeline control stays in the top module.

Test Plan:
- Borrow through zero: x=0x000, y=0x001, bin=0, out_ready=1 -> two cycles later out_valid=1, diff=0xFFF, bout=1, ovf=0.
- Signed overflow: x=0x800, y=0x001, bin=0 -> diff=0x7FF, bout=0, ovf=1. x=0x7FF, y=0xFFF -> diff=0x800, ovf=1, bout=1.
- Inter-slice borrow and bin:
  - x=0x040, y=0x001, bin=0 -> diff=0x03F, bout=0.
  - x=0x040, y=0x000, bin=1 -> diff=0x03F.
  - x=0x005, y=0x005, bin=1 -> diff=0xFFF, bout=1.
- Streaming with stall:
  - Send 4 back-to-back ops (x=0x100+i, y=i).
  - Hold out_ready=0 for cycles 3-5 -> in_ready=0 once both stages are full.
  - Outputs hold 0x100 stable. After release, results 0x100 x4 arrive in order with no loss or duplication.
- Reset mid-operation: two ops in flight, assert rst_n=0 for 1 cycle -> out_valid=0, diff=0, in_ready=1 the next cycle. No stale result appears afterward.
- Random compare: 10k random x, y, bin with random out_ready -> every output matches the reference model (x-y-bin) mod 4096, plus bout and ovf, in order.
